rv_seq_ctrl: RTL and testbench
==============================

# rv_seq_ctrl

Multi-cycle control sequencer for the RV32I register-file/ALU/data-memory datapath. It fetches a 32-bit instruction over a req/ack instruction-memory port and decodes it. It then drives the datapath's register addresses, `alu_ctrl` and memory/writeback strobes state by state. It also owns the PC and resolves BEQ/BNE using the datapath's `zero_flag`. Supported subset: R-type ALU ops, LW/SW with zero offset, BEQ/BNE. Anything else traps.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req` out 1: fetch request; held until accepted.
- `imem_addr` out 32: fetch address, equal to `pc`.
- `imem_ack` in 1: fetch accepted; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `zero_flag` in 1: ALU zero from the datapath.
- `rs1_addr`, `rs2_addr`, `rd_addr` out 5 each: register addresses to the datapath.
- `alu_ctrl` out 4: ALU opcode.
- `reg_write`, `mem_read`, `mem_write`, `mem_to_reg` out 1 each: datapath strobes.
- `pc` out 32: current instruction address.
- `retire` out 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` out 1: high while in TRAP.

## Operation
**ALU encoding.** ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001, PASSA 1010.

**States.** BOOT → FETCH → DECODE → EXEC → [MEM] → FETCH. TRAP is terminal.
- **BOOT:** one cycle after reset release; all strobes 0.
- **FETCH:**
  - `imem_req`=1.
  - On `imem_req && imem_ack`: latch `imem_rdata` into the IR and go to DECODE.
  - Without ack: stay in FETCH with `imem_addr` stable.
- **DECODE:**
  - Drive `rs1_addr`=IR[19:15], `rs2_addr`=IR[24:20], `rd_addr`=IR[11:7] and `alu_ctrl`.
  - Go to TRAP if the instruction is illegal; otherwise go to EXEC.
  - Register addresses and `alu_ctrl` are held unchanged from DECODE through the last state of the instruction.
- **R-type** (opcode 0110011). (funct3, funct7) mapping:
  - (000,00) ADD, (000,20) SUB, (001,00) SLL, (010,00) SLT, (011,00) SLTU.
  - (100,00) XOR, (101,00) SRL, (101,20) SRA, (110,00) OR, (111,00) AND.
  - Any other combination is illegal.
  - EXEC: `reg_write`=1 (0 if rd=x0), `mem_to_reg`=0, `retire`=1, pc←pc+4, then FETCH.
- **LW** (0000011, funct3 010, IR[31:20]==0):
  - Drive `rs2_addr`=0 and `alu_ctrl`=PASSA, so the address is rs1.
  - EXEC → MEM.
  - MEM: `mem_read`=1, `mem_to_reg`=1, `reg_write`=1 (0 if rd=x0), `retire`=1, pc←pc+4.
- **SW** (0100011, funct3 010, IR[31:25]==0 and IR[11:7]==0):
  - `alu_ctrl`=PASSA; address is rs1, write data is rs2.
  - EXEC → MEM.
  - MEM: `mem_write`=1, `retire`=1, pc←pc+4.
- **BEQ/BNE** (1100011, funct3 000/001):
  - `alu_ctrl`=SUB.
  - In EXEC, taken = `zero_flag` for BEQ, or !`zero_flag` for BNE.
  - Target = pc + sext(imm_b), computed mod 2^32 (wraps silently).
  - Not taken: pc←pc+4.
  - Taken with target[1]=1: go to TRAP, pc unchanged, no retire.
  - Otherwise `retire`=1 in EXEC.
- **Illegal:** any other opcode or field violation. No strobe is asserted, pc is unchanged, and the block goes to TRAP.
- **TRAP:**
  - `illegal`=1, all strobes 0, `imem_req`=0.
  - Left only via `rst`.
- **Strobe exclusivity:** at most one of `mem_read`/`mem_write` is high. Each strobe is high for exactly one cycle per instruction.

## Timing
- **Reset:** asynchronous and immediate, including mid-instruction. Reset values:
  - `pc`=`imem_addr`=RESET_PC.
  - `imem_req`, all strobes, `retire`, `illegal`, register addresses and `alu_ctrl` all 0.
  - IR=0, state BOOT.
  - A strobe active when reset asserts drops in the same cycle.
- **Startup:** first `imem_req` is in the 2nd cycle after `rst` deasserts (BOOT, then FETCH).
- **Latency with ack in the first FETCH cycle:**
  - R-type and branch: 3 cycles (FETCH, DECODE, EXEC).
  - LW/SW: 4 cycles.
  - Each cycle ack is delayed adds 1.
- **Next fetch:** the next FETCH begins the cycle after `retire`.
- **Memory timing:** the datapath's data-memory read is combinational and register-file writes occur at the clock edge ending the strobe cycle.
- **Outputs:** all outputs come directly from registers or decode of state/IR only. There are no combinational paths from `imem_ack`, `imem_rdata` or `zero_flag` to outputs.

## Test plan
- **R-type ADD:**
  - Stimulus: reset with RESET_PC=0x100, then fetch 0x002081B3 (ADD x3,x1,x2) with immediate ack.
  - Required: rs1=1, rs2=2, rd=3, alu_ctrl=0000; `reg_write` and `retire` in the 3rd cycle after the first `imem_req`; pc=0x104.
- **LW:**
  - Stimulus: 0x00032283 (LW x5,0(x6)).
  - Required: rs2_addr=0, alu_ctrl=1010; MEM cycle has `mem_read`=`mem_to_reg`=`reg_write`=1 for exactly one cycle; 4-cycle latency.
- **SW:**
  - Stimulus: 0x00742023 (SW x7,0(x8)).
  - Required: rs1=8, rs2=7, `mem_write` for one cycle, `reg_write` never high.
- **BEQ:**
  - Stimulus: 0xFE208CE3 (BEQ x1,x2,-8) at pc=0x104.
  - Required: with `zero_flag`=1, pc becomes 0xFC; with `zero_flag`=0, pc becomes 0x108.
- **Fetch stall and reset mid-operation:**
  - Stimulus: hold `imem_ack`=0 for 5 cycles.
  - Required: `imem_req` stays high with a stable address.
  - Stimulus: assert `rst` during an LW MEM cycle.
  - Required: strobes drop immediately and pc=RESET_PC.
- **Illegal:**
  - Stimulus: fetch 0x00000000, or LW with nonzero offset (0x00432283).
  - Required: `illegal`=1 from the cycle after DECODE, no strobes, `imem_req` stays 0 until reset.

Source files
------------

// File: rtl/rv_seq_ctrl.sv
// Multi-cycle control sequencer for an RV32I regfile/ALU/dmem datapath.
// Fetches over a req/ack port, decodes, and drives per-state datapath strobes; owns the PC.
module rv_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        zero_flag,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [3:0]  alu_ctrl,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic [31:0] pc,
  output logic        retire,
  output logic        illegal
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned AW   = 4;

  localparam logic [AW-1:0] ALU_ADD   = 4'b0000;
  localparam logic [AW-1:0] ALU_SUB   = 4'b0001;
  localparam logic [AW-1:0] ALU_AND   = 4'b0010;
  localparam logic [AW-1:0] ALU_OR    = 4'b0011;
  localparam logic [AW-1:0] ALU_XOR   = 4'b0100;
  localparam logic [AW-1:0] ALU_SLL   = 4'b0101;
  localparam logic [AW-1:0] ALU_SRL   = 4'b0110;
  localparam logic [AW-1:0] ALU_SRA   = 4'b0111;
  localparam logic [AW-1:0] ALU_SLT   = 4'b1000;
  localparam logic [AW-1:0] ALU_SLTU  = 4'b1001;
  localparam logic [AW-1:0] ALU_PASSA = 4'b1010;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_ILL, CLS_R, CLS_LW, CLS_SW, CLS_BR
  } cls_e;

  state_e          state_q;
  cls_e            cls_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ir_q;
  logic [XLEN-1:0] tgt_q;
  logic            taken_q;
  logic            req_q;
  logic [RW-1:0]   rs1_q, rs2_q, rd_q;
  logic [AW-1:0]   alu_q;
  logic            reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q;
  logic            retire_q, illegal_q;

  cls_e            dec_cls_d;
  logic [AW-1:0]   dec_alu_d;
  logic [RW-1:0]   dec_rs2_d;
  logic [XLEN-1:0] imm_b_d;
  logic [XLEN-1:0] br_tgt_d;
  logic            br_taken_d;
  logic [XLEN-1:0] pc_plus4_d;
  logic            unused_ir;

  // Classify the incoming instruction word so addresses/alu_ctrl are registered for DECODE.
  always_comb begin
    dec_cls_d = CLS_ILL;
    dec_alu_d = ALU_ADD;
    dec_rs2_d = imem_rdata[24:20];
    case (imem_rdata[6:0])
      OP_R: begin
        dec_cls_d = CLS_R;
        case ({imem_rdata[31:25], imem_rdata[14:12]})
          10'b0000000_000: dec_alu_d = ALU_ADD;
          10'b0100000_000: dec_alu_d = ALU_SUB;
          10'b0000000_001: dec_alu_d = ALU_SLL;
          10'b0000000_010: dec_alu_d = ALU_SLT;
          10'b0000000_011: dec_alu_d = ALU_SLTU;
          10'b0000000_100: dec_alu_d = ALU_XOR;
          10'b0000000_101: dec_alu_d = ALU_SRL;
          10'b0100000_101: dec_alu_d = ALU_SRA;
          10'b0000000_110: dec_alu_d = ALU_OR;
          10'b0000000_111: dec_alu_d = ALU_AND;
          default:         dec_cls_d = CLS_ILL;
        endcase
      end
      OP_LW: begin
        if (imem_rdata[14:12] == 3'b010 && imem_rdata[31:20] == 12'h000) begin
          dec_cls_d = CLS_LW;
          dec_alu_d = ALU_PASSA;
          dec_rs2_d = 5'd0;
        end
      end
      OP_SW: begin
        if (imem_rdata[14:12] == 3'b010 && imem_rdata[31:25] == 7'h00 &&
            imem_rdata[11:7] == 5'd0) begin
          dec_cls_d = CLS_SW;
          dec_alu_d = ALU_PASSA;
        end
      end
      OP_BR: begin
        if (imem_rdata[14:13] == 2'b00) begin
          dec_cls_d = CLS_BR;
          dec_alu_d = ALU_SUB;
        end
      end
      default: dec_cls_d = CLS_ILL;
    endcase
  end

  // Operands and SUB are presented from DECODE on, so zero_flag has settled by then;
  // resolving the branch at that edge keeps retire registered in EXEC.
  assign imm_b_d    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign br_tgt_d   = pc_q + imm_b_d;
  assign br_taken_d = ir_q[12] ? ~zero_flag : zero_flag;
  assign pc_plus4_d = pc_q + XLEN'(4);
  assign unused_ir  = ^{ir_q[24:13], ir_q[6:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BOOT;
      cls_q        <= CLS_ILL;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      tgt_q        <= '0;
      taken_q      <= 1'b0;
      req_q        <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      alu_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      retire_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      retire_q     <= 1'b0;
      case (state_q)
        S_BOOT: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_FETCH: begin
          if (req_q && imem_ack) begin
            ir_q    <= imem_rdata;
            cls_q   <= dec_cls_d;
            rs1_q   <= imem_rdata[19:15];
            rs2_q   <= dec_rs2_d;
            rd_q    <= imem_rdata[11:7];
            alu_q   <= dec_alu_d;
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (cls_q == CLS_ILL) begin
            state_q   <= S_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state_q <= S_EXEC;
            taken_q <= br_taken_d;
            tgt_q   <= br_tgt_d;
            if (cls_q == CLS_R) begin
              reg_write_q <= (rd_q != 5'd0);
              retire_q    <= 1'b1;
            end
            if (cls_q == CLS_BR) retire_q <= ~(br_taken_d & br_tgt_d[1]);
          end
        end
        S_EXEC: begin
          case (cls_q)
            CLS_LW: begin
              state_q      <= S_MEM;
              mem_read_q   <= 1'b1;
              mem_to_reg_q <= 1'b1;
              reg_write_q  <= (rd_q != 5'd0);
              retire_q     <= 1'b1;
            end
            CLS_SW: begin
              state_q     <= S_MEM;
              mem_write_q <= 1'b1;
              retire_q    <= 1'b1;
            end
            CLS_BR: begin
              if (taken_q && tgt_q[1]) begin
                state_q   <= S_TRAP;
                illegal_q <= 1'b1;
              end else begin
                pc_q    <= taken_q ? tgt_q : pc_plus4_d;
                state_q <= S_FETCH;
                req_q   <= 1'b1;
              end
            end
            default: begin
              pc_q    <= pc_plus4_d;
              state_q <= S_FETCH;
              req_q   <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          pc_q    <= pc_plus4_d;
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end
        S_TRAP: begin
          req_q <= 1'b0;
        end
        default: state_q <= S_TRAP;
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign rs1_addr   = rs1_q;
  assign rs2_addr   = rs2_q;
  assign rd_addr    = rd_q;
  assign alu_ctrl   = alu_q;
  assign reg_write  = reg_write_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_to_reg = mem_to_reg_q;
  assign retire     = retire_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Directed bench for rv_seq_ctrl: hand-computed expectations checked at each negedge.
module tb_rv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        zero_flag;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [3:0]  alu_ctrl;
  logic        reg_write, mem_read, mem_write, mem_to_reg;
  logic [31:0] pc;
  logic        retire, illegal;

  int n_chk  = 0;
  int n_fail = 0;

  rv_seq_ctrl #(.RESET_PC(32'h0000_0100)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .zero_flag  (zero_flag),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_addr    (rd_addr),
    .alu_ctrl   (alu_ctrl),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .pc         (pc),
    .retire     (retire),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packs all strobes as {reg_write, mem_read, mem_write, mem_to_reg, retire}.
  function automatic logic [31:0] strobes();
    return 32'({reg_write, mem_read, mem_write, mem_to_reg, retire});
  endfunction

  // Releases reset just after a rising edge, leaving the bench in the first FETCH cycle.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("boot_req", 32'(imem_req), 32'd0);
    @(negedge clk);
  endtask

  // Called in a FETCH cycle; acks immediately and returns in the DECODE cycle.
  task automatic fetch(input logic [31:0] instr, input logic [31:0] exp_pc);
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, exp_pc);
    imem_ack   = 1'b1;
    imem_rdata = instr;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("decode_req", 32'(imem_req), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    zero_flag  = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_pc", pc, 32'h100);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_strobes", strobes(), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_regs", 32'({rs1_addr, rs2_addr, rd_addr, alu_ctrl}), 32'd0);
    do_reset();

    // ADD x3,x1,x2 at 0x100
    fetch(32'h002081B3, 32'h100);
    chk("add_rs", 32'({rs1_addr, rs2_addr, rd_addr}), 32'({5'd1, 5'd2, 5'd3}));
    chk("add_alu", 32'(alu_ctrl), 32'h0);
    chk("add_dec_strobes", strobes(), 32'd0);
    @(negedge clk);
    chk("add_exec_strobes", strobes(), 32'b10001);
    chk("add_exec_pc", pc, 32'h100);
    @(negedge clk);
    chk("add_next_strobes", strobes(), 32'd0);
    chk("add_pc", pc, 32'h104);

    // BEQ x1,x2,-8 at 0x104, not taken
    zero_flag = 1'b0;
    fetch(32'hFE208CE3, 32'h104);
    chk("beq_alu", 32'(alu_ctrl), 32'h1);
    chk("beq_rs", 32'({rs1_addr, rs2_addr}), 32'({5'd1, 5'd2}));
    @(negedge clk);
    chk("beq_nt_strobes", strobes(), 32'b00001);
    @(negedge clk);
    chk("beq_nt_pc", pc, 32'h108);

    // BEQ taken from 0x104 after a fresh ADD
    do_reset();
    fetch(32'h002081B3, 32'h100);
    @(negedge clk);
    @(negedge clk);
    zero_flag = 1'b1;
    fetch(32'hFE208CE3, 32'h104);
    @(negedge clk);
    chk("beq_t_strobes", strobes(), 32'b00001);
    @(negedge clk);
    zero_flag = 1'b0;
    chk("beq_t_pc", pc, 32'h0FC);

    // LW x5,0(x6) at 0xFC
    fetch(32'h00032283, 32'h0FC);
    chk("lw_rs", 32'({rs1_addr, rs2_addr, rd_addr}), 32'({5'd6, 5'd0, 5'd5}));
    chk("lw_alu", 32'(alu_ctrl), 32'hA);
    @(negedge clk);
    chk("lw_exec_strobes", strobes(), 32'd0);
    @(negedge clk);
    chk("lw_mem_strobes", strobes(), 32'b11011);
    chk("lw_mem_pc", pc, 32'h0FC);
    @(negedge clk);
    chk("lw_next_strobes", strobes(), 32'd0);
    chk("lw_pc", pc, 32'h100);

    // SW x7,0(x8) at 0x100
    fetch(32'h00742023, 32'h100);
    chk("sw_rs", 32'({rs1_addr, rs2_addr}), 32'({5'd8, 5'd7}));
    chk("sw_alu", 32'(alu_ctrl), 32'hA);
    @(negedge clk);
    chk("sw_exec_strobes", strobes(), 32'd0);
    @(negedge clk);
    chk("sw_mem_strobes", strobes(), 32'b00101);
    @(negedge clk);
    chk("sw_next_strobes", strobes(), 32'd0);
    chk("sw_pc", pc, 32'h104);

    // SRA x1,x2,x3 at 0x104
    fetch(32'h403150B3, 32'h104);
    chk("sra_alu", 32'(alu_ctrl), 32'h7);
    chk("sra_rd", 32'(rd_addr), 32'd1);
    @(negedge clk);
    chk("sra_exec_strobes", strobes(), 32'b10001);
    @(negedge clk);
    chk("sra_pc", pc, 32'h108);

    // Five-cycle fetch stall at 0x108
    for (int i = 0; i < 5; i++) begin
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, 32'h108);
      @(negedge clk);
    end

    // LW, then reset in its MEM cycle
    fetch(32'h00032283, 32'h108);
    @(negedge clk);
    @(negedge clk);
    chk("lwrst_mem_read", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    chk("lwrst_strobes", strobes(), 32'd0);
    chk("lwrst_pc", pc, 32'h100);
    chk("lwrst_regs", 32'({rs2_addr, rs1_addr, alu_ctrl}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("lwrst_boot_req", 32'(imem_req), 32'd0);
    @(negedge clk);

    // BNE x1,x2,+2 taken to a misaligned target traps without retiring
    zero_flag = 1'b0;
    fetch(32'h00209163, 32'h100);
    @(negedge clk);
    chk("bne_mis_strobes", strobes(), 32'd0);
    @(negedge clk);
    chk("bne_mis_illegal", 32'(illegal), 32'd1);
    chk("bne_mis_pc", pc, 32'h100);
    chk("bne_mis_req", 32'(imem_req), 32'd0);

    // All-zero word is illegal
    do_reset();
    fetch(32'h0000_0000, 32'h100);
    chk("ill0_dec_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("ill0_illegal", 32'(illegal), 32'd1);
      chk("ill0_req", 32'(imem_req), 32'd0);
      chk("ill0_strobes", strobes(), 32'd0);
      @(negedge clk);
    end
    chk("ill0_pc", pc, 32'h100);

    // LW with nonzero offset is illegal
    do_reset();
    chk("lwoff_illegal_cleared", 32'(illegal), 32'd0);
    fetch(32'h00432283, 32'h100);
    @(negedge clk);
    chk("lwoff_illegal", 32'(illegal), 32'd1);
    chk("lwoff_strobes", strobes(), 32'd0);
    @(negedge clk);
    chk("lwoff_req", 32'(imem_req), 32'd0);
    chk("lwoff_pc", pc, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
